// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode constants and FSM state encoding for the LED sequencer
package led_seq_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_BLINK_ALL = 2'd0;
    localparam logic [MODE_W-1:0] MODE_WALK      = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BOUNCE    = 2'd2;
    localparam logic [MODE_W-1:0] MODE_COUNT     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - programmable prescaler emitting one tick every period+1 enabled cycles
module led_tick_gen #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;

    assign tick = enable && (count == period);

    // Count 0..period while enabled; parked at zero otherwise so a fresh run starts aligned
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - multi-LED blink/walk/bounce/count sequencer; optional LED_PATTERN_SEQ_REPEAT_EN
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int PERIOD_W       = 24,
    parameter int DEFAULT_PERIOD = 1,
    parameter int DEFAULT_MODE   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
`ifdef LED_PATTERN_SEQ_REPEAT_EN
    input  logic [7:0]          cfg_repeats,
    output logic                done,
`endif
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic                step_tick,
    output logic [NUM_LEDS-1:0] leds
);

    if (NUM_LEDS < 2) begin : g_num_leds_check
        $fatal(1, "led_pattern_seq: NUM_LEDS must be >= 2");
    end

    localparam logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [MODE_W-1:0]   RESET_MODE   = MODE_W'(DEFAULT_MODE);

    state_t              state, state_nxt;
    logic [NUM_LEDS-1:0] leds_nxt;
    logic [NUM_LEDS-1:0] pat_adv;
    logic                dir, dir_nxt, dir_adv;   // bounce direction: 0 = toward MSB
    logic [MODE_W-1:0]   mode_r, mode_nxt;
    logic [PERIOD_W-1:0] period_r, period_nxt;
    logic                tick;

`ifdef LED_PATTERN_SEQ_REPEAT_EN
    logic [7:0] repeats_r, repeats_nxt;
    logic [7:0] rep_cnt, rep_cnt_nxt, rep_inc;
    logic       pat_wrapped;
`endif

    // Starting pattern for each mode; a cycle completes when the pattern returns here
    function automatic logic [NUM_LEDS-1:0] initial_pattern(input logic [MODE_W-1:0] m);
        logic [NUM_LEDS-1:0] p;
        p = '0;
        case (m)
            MODE_BLINK_ALL: p = '1;
            MODE_COUNT:     p = '0;
            default:        p[0] = 1'b1;
        endcase
        return p;
    endfunction

    led_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (busy && !reset),
        .period (period_r),
        .tick   (tick)
    );

    assign busy      = (state != ST_IDLE);
    assign cfg_ready = (state == ST_IDLE) && !reset;
    assign step_tick = tick;

`ifdef LED_PATTERN_SEQ_REPEAT_EN
    assign rep_inc     = rep_cnt + 8'd1;
    assign pat_wrapped = (pat_adv == initial_pattern(mode_r));
`endif

    // Next pattern value for the active mode, plus bounce turn-around
    always_comb begin
        pat_adv = leds;
        dir_adv = dir;
        case (mode_r)
            MODE_BLINK_ALL: pat_adv = ~leds;
            MODE_WALK:      pat_adv = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
            MODE_BOUNCE: begin
                if (!dir) begin
                    pat_adv = leds << 1;
                    if (pat_adv[NUM_LEDS-1]) dir_adv = 1'b1;
                end else begin
                    pat_adv = leds >> 1;
                    if (pat_adv[0]) dir_adv = 1'b0;
                end
            end
            default:        pat_adv = leds + NUM_LEDS'(1);
        endcase
    end

    // FSM next state, config capture and LED update
    always_comb begin
        state_nxt  = state;
        leds_nxt   = leds;
        dir_nxt    = dir;
        mode_nxt   = mode_r;
        period_nxt = period_r;
`ifdef LED_PATTERN_SEQ_REPEAT_EN
        repeats_nxt = repeats_r;
        rep_cnt_nxt = rep_cnt;
        done        = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                leds_nxt = '0;
                if (cfg_valid) begin
                    mode_nxt   = cfg_mode;
                    period_nxt = cfg_period;
`ifdef LED_PATTERN_SEQ_REPEAT_EN
                    repeats_nxt = cfg_repeats;
`endif
                end
                // stop beats start; a same-cycle config write applies to this run
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                    leds_nxt  = initial_pattern(mode_nxt);
                    dir_nxt   = 1'b0;
`ifdef LED_PATTERN_SEQ_REPEAT_EN
                    rep_cnt_nxt = '0;
`endif
                end
            end
            ST_RUN: begin
                if (tick) begin
                    leds_nxt = pat_adv;
                    dir_nxt  = dir_adv;
`ifdef LED_PATTERN_SEQ_REPEAT_EN
                    if (pat_wrapped) begin
                        rep_cnt_nxt = rep_inc;
                        if (repeats_r != 8'd0 && rep_inc == repeats_r) begin
                            state_nxt = ST_IDLE;
                            leds_nxt  = '0;
                            done      = 1'b1;
                        end
                    end
`endif
                end
                if (stop && state_nxt == ST_RUN) state_nxt = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (tick) begin
                    leds_nxt  = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                leds_nxt  = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pattern and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            leds     <= '0;
            dir      <= 1'b0;
            mode_r   <= RESET_MODE;
            period_r <= RESET_PERIOD;
`ifdef LED_PATTERN_SEQ_REPEAT_EN
            repeats_r <= '0;
            rep_cnt   <= '0;
`endif
        end else begin
            leds     <= leds_nxt;
            dir      <= dir_nxt;
            mode_r   <= mode_nxt;
            period_r <= period_nxt;
`ifdef LED_PATTERN_SEQ_REPEAT_EN
            repeats_r <= repeats_nxt;
            rep_cnt   <= rep_cnt_nxt;
`endif
        end
    end

endmodule
